// File: rtl/data_router_pkg.sv
// Shared types for the input-buffer data router: read ops, read-scheduler states
// and the buffer-row depth derived from the conv stride.
package data_router_pkg;

    typedef enum logic [1:0] {
        OP_RR = 2'd0,
        OP_BR = 2'd1,
        OP_RP = 2'd2,
        OP_NE = 2'd3
    } rp_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RR   = 3'd2,
        S_BR   = 3'd3,
        S_RP   = 3'd4,
        S_FIN  = 3'd5
    } rd_sched_state_e;

    // Two rows per stride step: one being consumed while the next fills.
    function automatic int calc_bufh(input int stride);
        return 2 * stride;
    endfunction

endpackage

// File: rtl/data_router_rd_sched_if.sv
// Router read-command channel: op/bank/row/column with a valid/ready handshake.
interface data_router_rd_sched_if;
    import data_router_pkg::*;

    logic         cmd_valid;
    logic         cmd_ready;
    rp_op_e       rpsel;
    logic [7:0]   rbank;
    logic [7:0]   rrow;
    logic [27:0]  rcol;

    modport master (
        output cmd_valid, rpsel, rbank, rrow, rcol,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, rpsel, rbank, rrow, rcol,
        output cmd_ready
    );

endinterface

// File: rtl/data_router_credit_cnt.sv
// Saturating up/down row-fill credit counter (0..MAX) with a sticky overflow flag.
module data_router_credit_cnt #(
    parameter int MAX = 2,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    // A simultaneous increment and consume cancel out, even at the limit.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc_i && !dec_i) begin
            if (count_q == MAX_V) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/data_router_rd_sched.sv
// Read-side scheduler: turns a tile count into RR/BR/RP router read commands gated on
// row-fill credits. Optional stall/starve counters behind DATA_ROUTER_RD_SCHED_PERF_EN.
module data_router_rd_sched
    import data_router_pkg::*;
#(
    parameter int DW     = 32,
    parameter int POY    = 3,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1,
    parameter int BUFW   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            n_tiles,
    input  logic                   row_done,
    data_router_rd_sched_if.master cmd,
    output logic                   busy,
    output logic                   done,
    output logic                   credit_ovf
`ifdef DATA_ROUTER_RD_SCHED_PERF_EN
    ,
    output logic [31:0]            stall_cyc,
    output logic [31:0]            starve_cyc
`endif
);

    localparam int BUFH = calc_bufh(STRIDE);
    localparam int CW   = $clog2(BUFH + 1);
    localparam int RW   = (BUFH > 1) ? $clog2(BUFH) : 1;

    localparam logic [7:0]    KY_LAST    = 8'(KSIZE - 1);
    localparam logic [7:0]    J_LAST     = 8'(KSIZE - 2);
    localparam logic [7:0]    BANK_LAST  = 8'(POY - 1);
    localparam logic [7:0]    BANK_FIRST = (POY > 1) ? 8'd1 : 8'd0;
    localparam logic [27:0]   RCOL_FIRST = 28'(BUFW - KSIZE + 1);
    localparam logic [RW-1:0] RPTR_LAST  = RW'(BUFH - 1);

    if (KSIZE < 2 || DW < 1) begin : g_param_chk
        $error("data_router_rd_sched: KSIZE must be >= 2 and DW >= 1");
    end

    rd_sched_state_e state_q;
    logic [15:0]     tiles_q;
    logic [7:0]      ky_q;
    logic [7:0]      j_q;
    logic [RW-1:0]   rptr_q;
    logic            cmd_valid_q;
    rp_op_e          rpsel_q;
    logic [7:0]      rbank_q;
    logic [7:0]      rrow_q;
    logic [27:0]     rcol_q;
    logic            busy_q;
    logic            done_q;

    logic            hs;
    logic            tile_end;
    logic            start_acc;
    logic [CW-1:0]   credit;
    logic [RW-1:0]   rptr_d;

    assign hs        = cmd_valid_q && cmd.cmd_ready;
    assign tile_end  = (state_q == S_RP) && hs && (j_q == J_LAST);
    assign start_acc = (state_q == S_IDLE) && start;
    assign rptr_d    = (rptr_q == RPTR_LAST) ? '0 : rptr_q + RW'(1);

    data_router_credit_cnt #(
        .MAX (BUFH),
        .CW  (CW)
    ) u_credit (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (row_done),
        .dec_i   (tile_end),
        .count_o (credit),
        .ovf_o   (credit_ovf)
    );

    // Command fields are loaded on the edge that enters each issuing state, so they
    // stay registered and frozen while the consumer back-pressures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tiles_q     <= '0;
            ky_q        <= '0;
            j_q         <= '0;
            rptr_q      <= '0;
            cmd_valid_q <= 1'b0;
            rpsel_q     <= OP_RR;
            rbank_q     <= '0;
            rrow_q      <= '0;
            rcol_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        tiles_q <= n_tiles;
                        state_q <= (n_tiles == 16'd0) ? S_FIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (credit != '0) begin
                        state_q     <= S_RR;
                        cmd_valid_q <= 1'b1;
                        rpsel_q     <= OP_RR;
                        rbank_q     <= 8'd0;
                        rrow_q      <= 8'(rptr_q);
                        rcol_q      <= 28'd0;
                    end
                end
                S_RR: begin
                    if (hs) begin
                        state_q <= S_BR;
                        ky_q    <= 8'd1;
                        rpsel_q <= OP_BR;
                        rbank_q <= BANK_FIRST;
                    end
                end
                S_BR: begin
                    if (hs) begin
                        if (ky_q == KY_LAST) begin
                            state_q <= S_RP;
                            j_q     <= 8'd0;
                            rpsel_q <= OP_RP;
                            rbank_q <= 8'd0;
                            rcol_q  <= RCOL_FIRST;
                        end else begin
                            ky_q    <= ky_q + 8'd1;
                            rbank_q <= (rbank_q == BANK_LAST) ? 8'd0 : rbank_q + 8'd1;
                        end
                    end
                end
                S_RP: begin
                    if (hs) begin
                        if (j_q == J_LAST) begin
                            cmd_valid_q <= 1'b0;
                            rpsel_q     <= OP_RR;
                            rbank_q     <= 8'd0;
                            rrow_q      <= 8'd0;
                            rcol_q      <= 28'd0;
                            rptr_q      <= rptr_d;
                            tiles_q     <= tiles_q - 16'd1;
                            state_q     <= (tiles_q == 16'd1) ? S_FIN : S_WAIT;
                        end else begin
                            j_q    <= j_q + 8'd1;
                            rcol_q <= rcol_q + 28'd1;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.rpsel     = rpsel_q;
    assign cmd.rbank     = rbank_q;
    assign cmd.rrow      = rrow_q;
    assign cmd.rcol      = rcol_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef DATA_ROUTER_RD_SCHED_PERF_EN
    // Event 0: back-pressured command; event 1: waiting with no credit.
    logic [1:0] perf_ev;
    assign perf_ev[0] = cmd_valid_q && !cmd.cmd_ready;
    assign perf_ev[1] = (state_q == S_WAIT) && (credit == '0);

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (start_acc) begin
                cnt_q <= '0;
            end else if (perf_ev[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign stall_cyc  = g_perf[0].cnt_q;
    assign starve_cyc = g_perf[1].cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule
